// File: rtl/image_filter_pkg.sv
// rtl/image_filter_pkg.sv - shared constants, state type and window helper for the image filter path
package image_filter_pkg;

  localparam int PIX_W = 8;

  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } win_state_t;

  function automatic logic [PIX_W-1:0] win_elem(input logic [9*PIX_W-1:0] window, input int k);
    return window[k*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/image_window_3x3_if.sv
// rtl/image_window_3x3_if.sv - pixel stream in, 3x3 window stream out
interface image_window_3x3_if import image_filter_pkg::*; #(parameter int DATA_W = PIX_W);

  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic                in_sop;
  logic                in_eop;
  logic                in_ready;
  logic [9*DATA_W-1:0] out_window;
  logic                out_valid;
  logic                out_sop;
  logic                out_eop;
  logic                out_ready;
  logic                frame_err;

  modport master (
    output in_data, in_valid, in_sop, in_eop, out_ready,
    input  in_ready, out_window, out_valid, out_sop, out_eop, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop, out_ready,
    output in_ready, out_window, out_valid, out_sop, out_eop, frame_err
  );

endinterface

// File: rtl/image_line_buffer.sv
// rtl/image_line_buffer.sv - one image line of pixels, async read and sync write on a shared address
module image_line_buffer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 640,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/image_window_3x3.sv
// rtl/image_window_3x3.sv - raster pixel stream to 3x3 neighbourhood stream, one window per interior pixel
module image_window_3x3 import image_filter_pkg::*; #(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input logic               clk,
  input logic               reset,
  image_window_3x3_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  win_state_t          state, state_nx;
  logic [CW-1:0]       col, pix_col;
  logic [RW-1:0]       row, pix_row;
  logic                accept, proc, at_last, go_idle, err, emit;
  logic [DATA_W-1:0]   lb0_q, lb1_q;
  logic [9*DATA_W-1:0] win;
  logic                valid_q, sop_q, eop_q, err_q;

  // Reset kills a pending window combinationally so nothing leaks during the reset cycle.
  assign bus.out_valid  = valid_q && !reset;
  assign bus.in_ready   = bus.out_ready || !bus.out_valid;
  assign bus.out_sop    = sop_q && bus.out_valid;
  assign bus.out_eop    = eop_q && bus.out_valid;
  assign bus.out_window = win;
  assign bus.frame_err  = err_q;
  assign accept         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (proc) state_nx = go_idle ? IDLE : ACTIVE;
  end

  // A sop beat always lands at (0,0), whether it opens a frame or restarts one.
  always_comb begin
    proc    = accept && (state == ACTIVE || bus.in_sop);
    pix_col = bus.in_sop ? '0 : col;
    pix_row = bus.in_sop ? '0 : row;
    at_last = (pix_row == ROW_LAST) && (pix_col == COL_LAST);
    go_idle = bus.in_eop || at_last;
    err     = proc && ((state == ACTIVE && bus.in_sop) || (bus.in_eop != at_last));
    emit    = proc && (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
  end

  image_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb0 (
    .clk(clk), .we(proc), .addr(pix_col), .wdata(bus.in_data), .rdata(lb0_q)
  );

  image_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) lb1 (
    .clk(clk), .we(proc), .addr(pix_col), .wdata(lb0_q), .rdata(lb1_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      col     <= '0;
      row     <= '0;
      win     <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err;
      if (proc) begin
        for (int r = 0; r < 3; r++) begin
          win[(r*3)*DATA_W   +: DATA_W] <= win[(r*3+1)*DATA_W +: DATA_W];
          win[(r*3+1)*DATA_W +: DATA_W] <= win[(r*3+2)*DATA_W +: DATA_W];
        end
        win[WIN_TR*DATA_W +: DATA_W] <= lb1_q;
        win[WIN_MR*DATA_W +: DATA_W] <= lb0_q;
        win[WIN_BR*DATA_W +: DATA_W] <= bus.in_data;
        if (go_idle) begin
          col <= '0;
          row <= '0;
        end else if (pix_col == COL_LAST) begin
          col <= '0;
          row <= pix_row + 1'b1;
        end else begin
          col <= pix_col + 1'b1;
          row <= pix_row;
        end
      end
      if (emit) begin
        valid_q <= 1'b1;
        sop_q   <= (pix_row == ROW_TWO) && (pix_col == COL_TWO);
        eop_q   <= at_last;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
        sop_q   <= 1'b0;
        eop_q   <= 1'b0;
      end
    end
  end

endmodule
